rd_req_arbiter: RTL and testbench
=================================

# rd_req_arbiter

Round-robin arbiter sharing the single core-side read-request channel (cor_tx_rd_valid/addr/len into afu_io) among NUM_REQ independent read engines inside afu_core. It enforces host backpressure and a cap on outstanding cache lines (CLs). It routes each returning io_rx_rd response CL back to the requester that issued it, which works because afu_io returns read data in request order. The block sits between the afu_core engines and the afu_io read ports, clocked at the 400 MHz core clock.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_OUTSTANDING, 64, maximum CLs in flight (requested, not yet returned)
- OWNER_DEPTH, 16, owner-FIFO entries (issued requests awaiting data); power of 2
- clk  in  1  clock; one clock domain
- spl_reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_addr  in  NUM_REQ*58  per-requester CL address; slice i is [58*i+57:58*i]
- req_len  in  NUM_REQ*6  per-requester length in CLs; 0 means 64
- req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i] and req_ready[i]
- spl_tx_rd_almostfull  in  1  host read queue almost full
- cor_tx_rd_valid  out  1  issued request strobe to afu_io
- cor_tx_rd_addr  out  58  issued address
- cor_tx_rd_len  out  6  issued length (same encoding as req_len)
- io_rx_rd_valid  in  1  one returning CL
- io_rx_data  in  512  returning CL data
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning requester
- rsp_data  out  512  response data, shared bus
- rsp_last  out  1  final CL of the owning request
- err_unexpected_rsp  out  1  sticky; a CL arrived with the owner FIFO empty

## Operation
- len_eff = (len==0) ? 64 : len, computed at 7 bits.
- Requester i is eligible when all of the following hold:
  - req_valid[i] is high.
  - spl_tx_rd_almostfull is low.
  - The owner FIFO is not full.
  - outstanding + len_eff(i) <= MAX_OUTSTANDING.
- Winner: first eligible index at or after rr_ptr, wrapping. req_ready is combinational and asserts only for the winner; it is all zero when nothing is eligible.
- On handshake:
  - Register addr/len to cor_tx_rd_* with cor_tx_rd_valid=1 for exactly one cycle.
  - Push {owner id, len_eff} to the owner FIFO.
  - Set rr_ptr = winner+1 mod NUM_REQ.
  - Add len_eff to outstanding.
- A requester with a pending but ineligible (too-long) request does not block others; the lowest-priority position still rotates.
- outstanding counter: $clog2(MAX_OUTSTANDING+1) bits. Each cycle, next = outstanding + (issue ? len_eff : 0) − (io_rx_rd_valid ? 1 : 0). A simultaneous issue and return are both applied in the same cycle.
- Response routing on io_rx_rd_valid:
  - Head entry owner gets rsp_valid; io_rx_data goes to rsp_data.
  - beat_cnt increments per CL. When beat_cnt+1 == head len_eff: rsp_last=1, pop the head, clear beat_cnt.
- io_rx_rd_valid with the owner FIFO empty: the CL is dropped, err_unexpected_rsp is set (cleared only by reset), and outstanding is not decremented below 0.
- Owner FIFO full: all req_ready are low; returns continue, and a pop frees space on the next cycle.

## Timing
- Reset values:
  - cor_tx_rd_valid=0, cor_tx_rd_addr=0, cor_tx_rd_len=0.
  - rsp_valid=0, rsp_data=0, rsp_last=0.
  - err_unexpected_rsp=0.
  - outstanding=0, rr_ptr=0, owner FIFO empty, beat_cnt=0.
- req_ready is 0 during reset.
- Issue latency: handshake in cycle N, then cor_tx_rd_valid in cycle N+1. Throughput is one request per cycle.
- Response latency: io_rx_rd_valid in cycle N, then rsp_valid/rsp_data/rsp_last in cycle N+1. One CL per cycle, with no backpressure on the response side.
- Almostfull is sampled combinationally in the grant cycle; at most one request is issued in the cycle after it rises.
- Reset mid-operation: all state clears in the reset cycle. Responses to pre-reset requests arriving afterward hit the empty-FIFO error path.

## Test plan
- Single requester 0, addr=0x100, len=4; four io_rx_rd_valid beats: expect one cor_tx_rd_valid pulse with addr 0x100, len 4; rsp_valid[0] on four beats, rsp_last on the 4th; outstanding returns to 0.
- All 4 requesters hold valid, len=1, continuously: grants go 0,1,2,3,0,… one per cycle; cor_tx_rd_valid is high every cycle after the first.
- MAX_OUTSTANDING=64, req0 len=0 (64 CLs) issued, then req1 len=1 pending: req1 is stalled until the first CL returns; req1 issues the cycle after outstanding drops to 63.
- spl_tx_rd_almostfull held high for 10 cycles with requests pending: no req_ready, no cor_tx_rd_valid; issuing resumes the cycle almostfull falls.
- Interleaved requests req2 len=2 then req1 len=3, five returns: rsp_valid sequence is 2,2(last),1,1,1(last); simultaneous issue and return in one cycle leaves outstanding correct.
- io_rx_rd_valid after reset with no issued request: no rsp_valid, err_unexpected_rsp=1, outstanding stays 0.

Source files
------------

// File: rtl/rd_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// rd_req_arbiter_if
// Bundles every non-clock/reset signal of rd_req_arbiter.
//   requester side : req_valid/req_addr/req_len in, req_ready out (one-hot)
//   host side      : spl_tx_rd_almostfull in, cor_tx_rd_valid/addr/len out
//   return side    : io_rx_rd_valid/io_rx_data in,
//                    rsp_valid/rsp_data/rsp_last/err_unexpected_rsp out
// Modport slave is the arbiter; modport master is whoever drives the requests
// and the read returns (the engines plus afu_io, or a testbench).
// -----------------------------------------------------------------------------
interface rd_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*58-1:0] req_addr;
  logic [NUM_REQ*6-1:0]  req_len;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  spl_tx_rd_almostfull;
  logic                  cor_tx_rd_valid;
  logic [57:0]           cor_tx_rd_addr;
  logic [5:0]            cor_tx_rd_len;
  logic                  io_rx_rd_valid;
  logic [511:0]          io_rx_data;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [511:0]          rsp_data;
  logic                  rsp_last;
  logic                  err_unexpected_rsp;

  modport slave (
    input  req_valid, req_addr, req_len, spl_tx_rd_almostfull,
    input  io_rx_rd_valid, io_rx_data,
    output req_ready, cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_rd_len,
    output rsp_valid, rsp_data, rsp_last, err_unexpected_rsp
  );

  modport master (
    output req_valid, req_addr, req_len, spl_tx_rd_almostfull,
    output io_rx_rd_valid, io_rx_data,
    input  req_ready, cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_rd_len,
    input  rsp_valid, rsp_data, rsp_last, err_unexpected_rsp
  );
endinterface

// File: rtl/rd_req_arbiter.sv
// -----------------------------------------------------------------------------
// rd_req_arbiter
// Round-robin arbiter that shares one core-side read-request channel among
// NUM_REQ read engines. A request is granted only when the host queue is not
// almost full, the owner FIFO has room and the cache lines it adds keep the
// in-flight total within MAX_OUTSTANDING. Read data returns in request order,
// so a FIFO of {owner, length} tells which requester each returning CL
// belongs to and when its last CL has arrived.
// Ports:
//   clk        core clock
//   spl_reset  synchronous, active-high reset
//   bus        rd_req_arbiter_if.slave (request, issue and response signals)
// -----------------------------------------------------------------------------
module rd_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int OWNER_DEPTH     = 16
) (
  input  logic           clk,
  input  logic           spl_reset,
  rd_req_arbiter_if.slave bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(OWNER_DEPTH);

  // Arbitration
  logic [6:0]         len_eff [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    scan_idx;
  logic [ID_W-1:0]    winner;
  logic               grant_found;
  logic               issue;

  // State
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [5:0]         beat_cnt_q, beat_cnt_d;
  logic               cor_valid_q, cor_valid_d;
  logic [57:0]        cor_addr_q, cor_addr_d;
  logic [5:0]         cor_len_q, cor_len_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [511:0]       rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;
  logic               err_q, err_d;

  // Owner FIFO
  logic [ID_W-1:0]    fifo_id_q  [OWNER_DEPTH];
  logic [6:0]         fifo_len_q [OWNER_DEPTH];
  logic [PTR_W:0]     fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ID_W-1:0]    head_id;
  logic [6:0]         head_len;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_count == (PTR_W+1)'(OWNER_DEPTH));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head_id    = fifo_id_q[rd_ptr_q[PTR_W-1:0]];
  assign head_len   = fifo_len_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      len_eff[i]  = (bus.req_len[6*i +: 6] == 6'd0) ? 7'd64 : {1'b0, bus.req_len[6*i +: 6]};
      // An over-long request only masks itself; others remain grantable.
      eligible[i] = bus.req_valid[i] && !bus.spl_tx_rd_almostfull && !fifo_full &&
                    (int'(outstanding_q) + int'(len_eff[i]) <= MAX_OUTSTANDING);
    end
  end

  // First eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable of a combinational block gets a default before any
    // conditional assignment, so no latch can be inferred.
    grant_found = 1'b0;
    winner      = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        winner      = scan_idx;
      end
    end
  end

  assign issue         = grant_found && !spl_reset;
  assign bus.req_ready = issue ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    cor_valid_d = issue;
    cor_addr_d  = cor_addr_q;
    cor_len_d   = cor_len_q;
    rr_ptr_d    = rr_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    err_d       = err_q;

    if (issue) begin
      cor_addr_d = bus.req_addr[int'(winner)*58 +: 58];
      cor_len_d  = bus.req_len[int'(winner)*6 +: 6];
      wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(1);
      rr_ptr_d   = (int'(winner) == NUM_REQ-1) ? '0 : winner + ID_W'(1);
    end

    if (bus.io_rx_rd_valid) begin
      if (fifo_empty) begin
        // Nobody owns this CL: drop it and flag the protocol violation.
        err_d = 1'b1;
      end else begin
        rsp_valid_d = NUM_REQ'(1) << head_id;
        rsp_data_d  = bus.io_rx_data;
        if ({1'b0, beat_cnt_q} + 7'd1 == head_len) begin
          rsp_last_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(1);
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 6'd1;
        end
      end
    end

    // Issue and return in the same cycle are both applied; a stray return
    // never takes the count below zero.
    outstanding_d = outstanding_q
                  + (issue ? CNT_W'(len_eff[winner]) : CNT_W'(0))
                  - ((bus.io_rx_rd_valid && outstanding_q != '0) ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (spl_reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      cor_valid_q   <= 1'b0;
      cor_addr_q    <= '0;
      cor_len_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_last_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      cor_valid_q   <= cor_valid_d;
      cor_addr_q    <= cor_addr_d;
      cor_len_q     <= cor_len_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_last_q    <= rsp_last_d;
      err_q         <= err_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers alone decide which
  // entries are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (issue) begin
      fifo_id_q[wr_ptr_q[PTR_W-1:0]]  <= winner;
      fifo_len_q[wr_ptr_q[PTR_W-1:0]] <= len_eff[winner];
    end
  end

  assign bus.cor_tx_rd_valid    = cor_valid_q;
  assign bus.cor_tx_rd_addr     = cor_addr_q;
  assign bus.cor_tx_rd_len      = cor_len_q;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_data           = rsp_data_q;
  assign bus.rsp_last           = rsp_last_q;
  assign bus.err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rd_req_arbiter
// Drives rd_req_arbiter through directed scenarios and a randomized run. A
// queue-based reference model predicts the grant and all registered outputs
// every cycle; the directed scenarios also carry hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_rd_req_arbiter;

  localparam int N     = 4;
  localparam int MAXO  = 64;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic spl_reset;

  always #5 clk = ~clk;

  rd_req_arbiter_if #(.NUM_REQ(N)) bus ();

  rd_req_arbiter #(
    .NUM_REQ(N),
    .MAX_OUTSTANDING(MAXO),
    .OWNER_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .spl_reset(spl_reset),
    .bus(bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    int len;
  } own_t;

  own_t         m_q[$];
  int           m_out;
  int           m_rr;
  int           m_beat;
  bit           m_err;
  logic         exp_cor_valid;
  logic [57:0]  exp_addr;
  logic [5:0]   exp_len;
  logic [N-1:0] exp_rsp_valid;
  logic [511:0] exp_data;
  logic         exp_last;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int len_eff(input int i);
    int l;
    l = int'(bus.req_len[6*i +: 6]);
    return (l == 0) ? 64 : l;
  endfunction

  function automatic int model_winner();
    int i;
    if (spl_reset) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (bus.req_valid[i] && !bus.spl_tx_rd_almostfull && m_q.size() < DEPTH &&
          m_out + len_eff(i) <= MAXO)
        return i;
    end
    return -1;
  endfunction

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic cycle();
    int           w;
    int           dec;
    bit           rx;
    logic [511:0] d;
    logic [N-1:0] exp_ready;
    #1;
    w         = model_winner();
    exp_ready = (w < 0) ? '0 : (N'(1) << w);
    check("req_ready", 512'(bus.req_ready), 512'(exp_ready));
    rx = bus.io_rx_rd_valid;
    d  = bus.io_rx_data;
    @(posedge clk);
    if (spl_reset) begin
      m_q.delete();
      m_out = 0; m_rr = 0; m_beat = 0; m_err = 1'b0;
      exp_cor_valid = 1'b0; exp_addr = '0; exp_len = '0;
      exp_rsp_valid = '0; exp_data = '0; exp_last = 1'b0;
    end else begin
      dec           = (rx && m_out > 0) ? 1 : 0;
      exp_rsp_valid = '0;
      exp_last      = 1'b0;
      // Returns are matched against the queue as it stood before this edge.
      if (rx) begin
        if (m_q.size() == 0) begin
          m_err = 1'b1;
        end else begin
          exp_rsp_valid = N'(1) << m_q[0].id;
          exp_data      = d;
          m_beat++;
          if (m_beat == m_q[0].len) begin
            exp_last = 1'b1;
            m_beat   = 0;
            void'(m_q.pop_front());
          end
        end
      end
      exp_cor_valid = (w >= 0);
      if (w >= 0) begin
        exp_addr = bus.req_addr[58*w +: 58];
        exp_len  = bus.req_len[6*w +: 6];
        m_q.push_back('{id: w, len: len_eff(w)});
        m_rr  = (w + 1) % N;
        m_out = m_out + len_eff(w);
      end
      m_out = m_out - dec;
    end
    #1;
    check("cor_tx_rd_valid", 512'(bus.cor_tx_rd_valid), 512'(exp_cor_valid));
    check("cor_tx_rd_addr", 512'(bus.cor_tx_rd_addr), 512'(exp_addr));
    check("cor_tx_rd_len", 512'(bus.cor_tx_rd_len), 512'(exp_len));
    check("rsp_valid", 512'(bus.rsp_valid), 512'(exp_rsp_valid));
    check("rsp_data", bus.rsp_data, exp_data);
    check("rsp_last", 512'(bus.rsp_last), 512'(exp_last));
    check("err_unexpected_rsp", 512'(bus.err_unexpected_rsp), 512'(m_err));
    check("outstanding", 512'(dut.outstanding_q), 512'(m_out));
    @(negedge clk);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input bit v, input logic [57:0] a, input logic [5:0] l);
    bus.req_valid[i]         = v;
    bus.req_addr[58*i +: 58] = a;
    bus.req_len[6*i +: 6]    = l;
  endtask

  task automatic do_reset();
    spl_reset                = 1'b1;
    bus.req_valid            = '0;
    bus.spl_tx_rd_almostfull = 1'b0;
    bus.io_rx_rd_valid       = 1'b0;
    cycle();
    cycle();
    spl_reset = 1'b0;
  endtask

  task automatic rx_beat(input logic [N-1:0] ev, input bit el);
    bus.io_rx_rd_valid = 1'b1;
    bus.io_rx_data     = {16{$urandom}};
    cycle();
    check("lit_rsp_valid", 512'(bus.rsp_valid), 512'(ev));
    check("lit_rsp_last", 512'(bus.rsp_last), 512'(el));
    bus.io_rx_rd_valid = 1'b0;
  endtask

  task automatic lit_ready(input logic [N-1:0] ev);
    #1;
    check("lit_req_ready", 512'(bus.req_ready), 512'(ev));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    spl_reset                = 1'b1;
    bus.req_valid            = '0;
    bus.req_addr             = '0;
    bus.req_len              = '0;
    bus.spl_tx_rd_almostfull = 1'b0;
    bus.io_rx_rd_valid       = 1'b0;
    bus.io_rx_data           = '0;
    @(negedge clk);

    // Reset state, with requests asserted during reset.
    bus.req_valid = '1;
    lit_ready(4'b0000);
    do_reset();
    check("lit_reset_cor_valid", 512'(bus.cor_tx_rd_valid), 512'(0));
    check("lit_reset_rsp_valid", 512'(bus.rsp_valid), 512'(0));
    check("lit_reset_rsp_data", bus.rsp_data, 512'(0));
    check("lit_reset_err", 512'(bus.err_unexpected_rsp), 512'(0));

    // Single request, four beats.
    set_req(0, 1'b1, 58'h100, 6'd4);
    lit_ready(4'b0001);
    cycle();
    set_req(0, 1'b0, 58'h0, 6'd0);
    check("lit_single_cor_valid", 512'(bus.cor_tx_rd_valid), 512'(1));
    check("lit_single_addr", 512'(bus.cor_tx_rd_addr), 512'(58'h100));
    check("lit_single_len", 512'(bus.cor_tx_rd_len), 512'(4));
    check("lit_single_out", 512'(dut.outstanding_q), 512'(4));
    rx_beat(4'b0001, 1'b0);
    rx_beat(4'b0001, 1'b0);
    rx_beat(4'b0001, 1'b0);
    rx_beat(4'b0001, 1'b1);
    cycle();
    check("lit_single_out_end", 512'(dut.outstanding_q), 512'(0));
    check("lit_single_cor_idle", 512'(bus.cor_tx_rd_valid), 512'(0));

    // Round robin with all requesters continuously valid.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 58'(i + 1), 6'd1);
    for (int k = 0; k < 8; k++) begin
      lit_ready(N'(1) << (k % N));
      cycle();
      check("lit_rr_cor_valid", 512'(bus.cor_tx_rd_valid), 512'(1));
      check("lit_rr_addr", 512'(bus.cor_tx_rd_addr), 512'((k % N) + 1));
    end
    bus.req_valid = '0;

    // Outstanding cap: 64 CLs in flight block a 1-CL request until one returns.
    do_reset();
    set_req(0, 1'b1, 58'h200, 6'd0);
    lit_ready(4'b0001);
    cycle();
    set_req(0, 1'b0, 58'h0, 6'd0);
    set_req(1, 1'b1, 58'h300, 6'd1);
    check("lit_cap_out", 512'(dut.outstanding_q), 512'(64));
    lit_ready(4'b0000);
    cycle();
    lit_ready(4'b0000);
    cycle();
    bus.io_rx_rd_valid = 1'b1;
    bus.io_rx_data     = {16{$urandom}};
    lit_ready(4'b0000);
    cycle();
    bus.io_rx_rd_valid = 1'b0;
    check("lit_cap_out63", 512'(dut.outstanding_q), 512'(63));
    lit_ready(4'b0010);
    cycle();
    set_req(1, 1'b0, 58'h0, 6'd0);
    check("lit_cap_cor_valid", 512'(bus.cor_tx_rd_valid), 512'(1));
    check("lit_cap_addr", 512'(bus.cor_tx_rd_addr), 512'(58'h300));

    // Almost-full backpressure.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 58'(16 * i), 6'd1);
    bus.spl_tx_rd_almostfull = 1'b1;
    for (int k = 0; k < 10; k++) begin
      lit_ready(4'b0000);
      cycle();
      check("lit_af_cor_valid", 512'(bus.cor_tx_rd_valid), 512'(0));
    end
    bus.spl_tx_rd_almostfull = 1'b0;
    lit_ready(4'b0001);
    cycle();
    check("lit_af_resume", 512'(bus.cor_tx_rd_valid), 512'(1));
    bus.spl_tx_rd_almostfull = 1'b1;
    lit_ready(4'b0000);
    cycle();
    check("lit_af_rise", 512'(bus.cor_tx_rd_valid), 512'(0));
    bus.req_valid            = '0;
    bus.spl_tx_rd_almostfull = 1'b0;

    // Interleaved owners, issue and return in the same cycle.
    do_reset();
    set_req(2, 1'b1, 58'h20, 6'd2);
    cycle();
    set_req(2, 1'b0, 58'h0, 6'd0);
    set_req(1, 1'b1, 58'h10, 6'd3);
    rx_beat(4'b0100, 1'b0);
    set_req(1, 1'b0, 58'h0, 6'd0);
    check("lit_il_cor_len", 512'(bus.cor_tx_rd_len), 512'(3));
    check("lit_il_out", 512'(dut.outstanding_q), 512'(4));
    rx_beat(4'b0100, 1'b1);
    rx_beat(4'b0010, 1'b0);
    rx_beat(4'b0010, 1'b0);
    rx_beat(4'b0010, 1'b1);
    check("lit_il_out_end", 512'(dut.outstanding_q), 512'(0));

    // Unexpected return with nothing issued.
    do_reset();
    rx_beat(4'b0000, 1'b0);
    check("lit_err_set", 512'(bus.err_unexpected_rsp), 512'(1));
    check("lit_err_out", 512'(dut.outstanding_q), 512'(0));
    cycle();
    check("lit_err_sticky", 512'(bus.err_unexpected_rsp), 512'(1));

    // Reset mid-operation: the late return hits the error path.
    do_reset();
    set_req(0, 1'b1, 58'h40, 6'd2);
    cycle();
    set_req(0, 1'b0, 58'h0, 6'd0);
    spl_reset = 1'b1;
    cycle();
    spl_reset = 1'b0;
    check("lit_midrst_err_clear", 512'(bus.err_unexpected_rsp), 512'(0));
    rx_beat(4'b0000, 1'b0);
    check("lit_midrst_err", 512'(bus.err_unexpected_rsp), 512'(1));

    // Randomized traffic: slow-return phases fill the FIFO and the CL budget,
    // fast-return phases drain them.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int rx_pct;
      rx_pct = (c % 600 < 250) ? 8 : 75;
      for (int i = 0; i < N; i++) begin
        set_req(i, ($urandom % 3) != 0, 58'({$urandom, $urandom}),
                (($urandom % 10) == 0) ? 6'd0 : 6'($urandom_range(1, 8)));
      end
      bus.spl_tx_rd_almostfull = (($urandom % 6) == 0);
      bus.io_rx_rd_valid       = (m_q.size() > 0 && ($urandom % 100) < rx_pct) ||
                                 (($urandom % 400) == 0);
      bus.io_rx_data           = {16{$urandom}};
      spl_reset                = (($urandom % 700) == 0);
      cycle();
    end
    spl_reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
